// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the block-copy DMA: FSM state encodings and the
// memory opcodes it drives (SDW store opcode, DMA_IDLE_OP for non-writes).
package mem_copy_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

    // Store-data-word opcode understood by the data memory.
    localparam logic [5:0] SDW         = 6'h2B;
    // Opcode driven on every cycle that is not a write; must differ from SDW.
    localparam logic [5:0] DMA_IDLE_OP = 6'h00;

endpackage

// File: rtl/mem_copy_dma_addr_gen.sv
// dma_addr_gen: source/destination word addresses for word index i.
// Ascending: base + i. Descending: base + (len - 1 - i). All mod 256.
// Only the low 8 bits of len and i are needed: i < len <= 256, and
// len = 256 gives the same mod-256 offset as len = 0.
module dma_addr_gen (
    input  logic [7:0] src_base,
    input  logic [7:0] dst_base,
    input  logic [7:0] idx,
    input  logic [7:0] len_lo,
    input  logic       desc,
    output logic [7:0] src_addr,
    output logic [7:0] dst_addr
);

    logic [7:0] offset;

    // Word offset from the base addresses; len - 1 - i == len + ~i (mod 256).
    always_comb begin
        offset   = desc ? (len_lo + ~idx) : idx;
        src_addr = src_base + offset;
        dst_addr = dst_base + offset;
    end

endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: copies len words from src to dst, one read cycle and one
// write cycle per word, with a one-cycle DONE pulse at the end.
// Optional macro DMA_MEMMOVE_EN: overlapping forward copies run descending
// so the source data is preserved.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  src,
    input  logic [7:0]  dst,
    input  logic [8:0]  len,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [5:0]  mem_opcode,
    input  logic [31:0] mem_rdata
);

    dma_state_e  state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  dst_q, dst_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  idx_q, idx_d;
    logic [31:0] hold_q, hold_d;
    logic        desc_q, desc_d;

    logic        overlap;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;

`ifdef DMA_MEMMOVE_EN
    // Forward overlap (9-bit, no wrap): copying upward would clobber source.
    always_comb begin
        overlap = ({1'b0, dst} > {1'b0, src}) && ({1'b0, dst} < ({1'b0, src} + len));
    end
`else
    // Every copy runs ascending.
    always_comb begin
        overlap = 1'b0;
    end
`endif

    dma_addr_gen u_addr_gen (
        .src_base (src_q),
        .dst_base (dst_q),
        .idx      (idx_q[7:0]),
        .len_lo   (len_q[7:0]),
        .desc     (desc_q),
        .src_addr (src_addr),
        .dst_addr (dst_addr)
    );

    // State and datapath registers; reset aborts any copy in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            desc_q  <= desc_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        desc_d  = desc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_d   = src;
                        dst_d   = dst;
                        len_d   = len;
                        idx_d   = '0;
                        desc_d  = overlap;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                hold_d  = mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                idx_d   = idx_q + 9'd1;
                state_d = (idx_d == len_q) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs decoded from state only, so reset drops SDW at once.
    always_comb begin
        mem_addr   = '0;
        mem_opcode = DMA_IDLE_OP;
        mem_wdata  = hold_q;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        case (state_q)
            ST_READ: begin
                mem_addr = {24'd0, src_addr};
            end
            ST_WRITE: begin
                mem_addr   = {24'd0, dst_addr};
                mem_opcode = SDW;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma with a 256-word behavioural memory
// that returns read data combinationally and commits writes on negedge.
module tb_mem_copy_dma;

    localparam logic [5:0] OP_SDW  = 6'h2B;
    localparam logic [5:0] OP_IDLE = 6'h00;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  src = '0;
    logic [7:0]  dst = '0;
    logic [8:0]  len = '0;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [5:0]  mem_opcode;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] exp_mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;
    int writes = 0;
    int hi_addr_err = 0;

    mem_copy_dma dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_opcode (mem_opcode),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(negedge CLK) begin
        if (mem_addr[31:8] != 24'd0) hi_addr_err++;
        if (mem_opcode === OP_SDW) begin
            mem[mem_addr[7:0]] = mem_wdata;
            writes++;
        end
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int k = 0; k < 256; k++) mem[k] = rnd ? $urandom : k;
    endtask

    // Reference: word-by-word copy in the order the spec prescribes.
    task automatic model_copy(input int s, input int d, input int n);
        bit desc_dir;
        for (int k = 0; k < 256; k++) exp_mem[k] = mem[k];
        desc_dir = 1'b0;
`ifdef DMA_MEMMOVE_EN
        desc_dir = (d > s) && (d < s + n);
`endif
        if (desc_dir) begin
            for (int k = n - 1; k >= 0; k--) exp_mem[(d + k) % 256] = exp_mem[(s + k) % 256];
        end else begin
            for (int k = 0; k < n; k++) exp_mem[(d + k) % 256] = exp_mem[(s + k) % 256];
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic do_copy(input string tag, input int s, input int d, input int n, input bit disturb);
        int busy_cyc = 0;
        int done_cnt = 0;
        int done_at = 0;
        bit finished = 1'b0;
        model_copy(s, d, n);
        @(negedge CLK);
        writes = 0;
        start = 1'b1;
        src = s[7:0];
        dst = d[7:0];
        len = n[8:0];
        @(negedge CLK);
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (disturb && c == 3) begin
                start = 1'b1;
                src = 8'($urandom);
                dst = 8'($urandom);
                len = 9'($urandom_range(1, 256));
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        check({tag, " finished"}, finished, 1);
        check({tag, " busy_cycles"}, busy_cyc, 2 * n + 1);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_at, 2 * n + 1);
        check({tag, " writes"}, writes, n);
        check_mem({tag, " mem_words_wrong"});
    endtask

    initial begin
        int s, d, n;
        preload(1'b0);
        repeat (2) @(negedge CLK);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst mem_opcode", mem_opcode, OP_IDLE);
        RST = 1'b0;

        preload(1'b0);
        do_copy("basic_10_100_4", 10, 100, 4, 1'b0);
        check("basic mem[103]", mem[103], 13);
        do_copy("len0", 7, 9, 0, 1'b0);
        preload(1'b0);
        do_copy("overlap_20_22_4", 20, 22, 4, 1'b0);
        preload(1'b0);
        do_copy("wrap_254_0_3", 254, 0, 3, 1'b0);
        check("wrap mem[2]", mem[2], 254);
        preload(1'b0);
        do_copy("restart_ignored", 10, 100, 4, 1'b1);

        // Reset during the second WRITE, before its committing negedge.
        preload(1'b0);
        model_copy(50, 150, 1);
        @(negedge CLK);
        writes = 0;
        start = 1'b1;
        src = 8'd50;
        dst = 8'd150;
        len = 9'd4;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort opcode", mem_opcode, OP_IDLE);
        check("abort mem_addr", mem_addr, 0);
        repeat (2) @(negedge CLK);
        check("abort writes", writes, 1);
        check_mem("abort mem_words_wrong");
        RST = 1'b0;

        for (int r = 0; r < 12; r++) begin
            preload(1'b1);
            s = $urandom_range(0, 255);
            n = (r % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(1, 256);
            d = (r % 2 == 0) ? (s + $urandom_range(1, 8)) % 256 : $urandom_range(0, 255);
            do_copy($sformatf("rand%0d", r), s, d, n, r[0]);
        end

        check("upper_addr_bits", hi_addr_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
